mips_pipeline: RTL and testbench



---
 rtl/mips_pipeline.sv | 324 ++++++++++++++++++++++++++++++++
 tb/tb_mips_pipeline.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_pipeline.sv
// Five-stage MIPS subset CPU (IF/ID/EX/MEM/WB) with EX forwarding, load-use stall,
// ID-stage jumps and EX-stage branches; ROM, RAM and PC are all word-indexed.

module mips_regbank (
  input  logic        clk,
  input  logic        clr,
  input  logic        we_i,
  input  logic [4:0]  wa_i,
  input  logic [31:0] wd_i,
  input  logic [4:0]  ra1_i,
  input  logic [4:0]  ra2_i,
  output logic [31:0] rd1_o,
  output logic [31:0] rd2_o
);
  logic [31:0] RB [0:31];

  // NOTE: unlike the memories, the register file is architecturally cleared by reset,
  // so the whole array lives in the async-reset process and is updated with <=.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      for (int i = 0; i < 32; i++) RB[i] <= '0;
    end else if (we_i && (wa_i != 5'd0)) begin
      RB[wa_i] <= wd_i;
    end
  end

  // NOTE: every output gets a default first, so no path through this block infers a latch.
  always_comb begin
    rd1_o = RB[ra1_i];
    rd2_o = RB[ra2_i];
    if (ra1_i == 5'd0)                      rd1_o = '0;
    else if (we_i && (wa_i == ra1_i))       rd1_o = wd_i;
    if (ra2_i == 5'd0)                      rd2_o = '0;
    else if (we_i && (wa_i == ra2_i))       rd2_o = wd_i;
  end
endmodule

module mips_ram (
  input  logic        clk,
  input  logic        we_i,
  input  logic [7:0]  addr_i,
  input  logic [31:0] wd_i,
  output logic [31:0] rd_o
);
  logic [31:0] mem_array [0:255];

  // NOTE: memory contents survive reset, so this array has no reset branch at all.
  always_ff @(posedge clk) begin
    if (we_i) mem_array[addr_i] <= wd_i;
  end

  assign rd_o = mem_array[addr_i];
endmodule

module mips_rom (
  input  logic        clk,
  input  logic        we_i,
  input  logic [7:0]  addr_i,
  input  logic [31:0] wd_i,
  output logic [31:0] rd_o
);
  logic [31:0] mem_array [0:255];

  // The load port is tied off inside the core; programs are placed by the environment.
  always_ff @(posedge clk) begin
    if (we_i) mem_array[addr_i] <= wd_i;
  end

  assign rd_o = mem_array[addr_i];
endmodule

module mips_pipeline (
  input  logic        clk,
  input  logic        clr,
  output logic [31:0] alu
);
  typedef enum logic [2:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_NOR, ALU_SLT
  } alu_op_e;

  typedef struct packed {
    logic    reg_write;
    logic    mem_to_reg;
    logic    mem_read;
    logic    mem_write;
    logic    alu_src;
    logic    branch;
    alu_op_e alu_op;
  } ctrl_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } ifid_t;

  typedef struct packed {
    ctrl_t       ctrl;
    logic [31:0] pc;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic [31:0] imm;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  dst;
  } idex_t;

  typedef struct packed {
    logic        reg_write;
    logic        mem_to_reg;
    logic        mem_write;
    logic [31:0] res;
    logic [31:0] store;
    logic [4:0]  dst;
  } exmem_t;

  typedef struct packed {
    logic        reg_write;
    logic        mem_to_reg;
    logic [31:0] res;
    logic [31:0] rdata;
    logic [4:0]  dst;
  } memwb_t;

  logic [31:0] pc_q, pc_d;
  ifid_t       ifid_q, ifid_d;
  idex_t       idex_q, idex_d;
  exmem_t      exmem_q, exmem_d;
  memwb_t      memwb_q, memwb_d;

  logic [31:0] instr_if, ram_rd, wb_data;

  mips_rom INSmemory (
    .clk    (clk),
    .we_i   (1'b0),
    .addr_i (pc_q[7:0]),
    .wd_i   (32'd0),
    .rd_o   (instr_if)
  );

  // ---------------- ID ----------------
  logic [5:0]  op_id, funct_id;
  logic [4:0]  rs_id, rt_id, rd_id;
  logic [15:0] imm16_id;
  logic [31:0] rs_val_id, rt_val_id, imm_id;
  logic [4:0]  dst_id;
  ctrl_t       ctrl_id;
  logic        jump_id;

  assign op_id    = ifid_q.instr[31:26];
  assign rs_id    = ifid_q.instr[25:21];
  assign rt_id    = ifid_q.instr[20:16];
  assign rd_id    = ifid_q.instr[15:11];
  assign funct_id = ifid_q.instr[5:0];
  assign imm16_id = ifid_q.instr[15:0];

  always_comb begin
    ctrl_id = '0;
    dst_id  = rt_id;
    imm_id  = {{16{imm16_id[15]}}, imm16_id};
    jump_id = 1'b0;
    case (op_id)
      6'h00: begin
        dst_id            = rd_id;
        ctrl_id.reg_write = 1'b1;
        case (funct_id)
          6'h20:   ctrl_id.alu_op = ALU_ADD;
          6'h22:   ctrl_id.alu_op = ALU_SUB;
          6'h24:   ctrl_id.alu_op = ALU_AND;
          6'h25:   ctrl_id.alu_op = ALU_OR;
          6'h27:   ctrl_id.alu_op = ALU_NOR;
          6'h2A:   ctrl_id.alu_op = ALU_SLT;
          default: ctrl_id.reg_write = 1'b0;
        endcase
      end
      6'h23: begin
        ctrl_id.reg_write  = 1'b1;
        ctrl_id.mem_to_reg = 1'b1;
        ctrl_id.mem_read   = 1'b1;
        ctrl_id.alu_src    = 1'b1;
      end
      6'h2B: begin
        ctrl_id.mem_write = 1'b1;
        ctrl_id.alu_src   = 1'b1;
      end
      6'h08: begin
        ctrl_id.reg_write = 1'b1;
        ctrl_id.alu_src   = 1'b1;
      end
      6'h0D: begin
        ctrl_id.reg_write = 1'b1;
        ctrl_id.alu_src   = 1'b1;
        ctrl_id.alu_op    = ALU_OR;
        imm_id            = {16'd0, imm16_id};
      end
      6'h04: begin
        ctrl_id.branch = 1'b1;
        ctrl_id.alu_op = ALU_SUB;
      end
      6'h02:   jump_id = 1'b1;
      default: ;
    endcase
  end

  mips_regbank Reg_Bank0 (
    .clk   (clk),
    .clr   (clr),
    .we_i  (memwb_q.reg_write),
    .wa_i  (memwb_q.dst),
    .wd_i  (wb_data),
    .ra1_i (rs_id),
    .ra2_i (rt_id),
    .rd1_o (rs_val_id),
    .rd2_o (rt_val_id)
  );

  // A load in EX cannot supply its data until WB, so its direct consumer waits a cycle.
  logic load_use;
  assign load_use = idex_q.ctrl.mem_read &&
                    ((idex_q.rt == rs_id) || (idex_q.rt == rt_id));

  // ---------------- EX ----------------
  logic [31:0] fwd_a, fwd_b, opnd_b, alu_res, br_target;
  logic        br_taken;

  always_comb begin
    fwd_a = idex_q.rs_val;
    fwd_b = idex_q.rt_val;
    if (exmem_q.reg_write && (exmem_q.dst != 5'd0) && (exmem_q.dst == idex_q.rs))
      fwd_a = exmem_q.res;
    else if (memwb_q.reg_write && (memwb_q.dst != 5'd0) && (memwb_q.dst == idex_q.rs))
      fwd_a = wb_data;
    if (exmem_q.reg_write && (exmem_q.dst != 5'd0) && (exmem_q.dst == idex_q.rt))
      fwd_b = exmem_q.res;
    else if (memwb_q.reg_write && (memwb_q.dst != 5'd0) && (memwb_q.dst == idex_q.rt))
      fwd_b = wb_data;
  end

  assign opnd_b = idex_q.ctrl.alu_src ? idex_q.imm : fwd_b;

  always_comb begin
    alu_res = fwd_a + opnd_b;
    case (idex_q.ctrl.alu_op)
      ALU_SUB: alu_res = fwd_a - opnd_b;
      ALU_AND: alu_res = fwd_a & opnd_b;
      ALU_OR:  alu_res = fwd_a | opnd_b;
      ALU_NOR: alu_res = ~(fwd_a | opnd_b);
      ALU_SLT: alu_res = {31'd0, $signed(fwd_a) < $signed(opnd_b)};
      default: alu_res = fwd_a + opnd_b;
    endcase
  end

  assign alu       = alu_res;
  assign br_taken  = idex_q.ctrl.branch && (fwd_a == fwd_b);
  assign br_target = idex_q.pc + 32'd1 + idex_q.imm;

  // ---------------- MEM / WB ----------------
  mips_ram RAM (
    .clk    (clk),
    .we_i   (exmem_q.mem_write),
    .addr_i (exmem_q.res[7:0]),
    .wd_i   (exmem_q.store),
    .rd_o   (ram_rd)
  );

  assign wb_data = memwb_q.mem_to_reg ? memwb_q.rdata : memwb_q.res;

  // A taken branch outranks the stall, which in turn outranks a jump in ID.
  always_comb begin
    pc_d           = pc_q + 32'd1;
    ifid_d.pc      = pc_q;
    ifid_d.instr   = instr_if;
    idex_d.ctrl    = ctrl_id;
    idex_d.pc      = ifid_q.pc;
    idex_d.rs_val  = rs_val_id;
    idex_d.rt_val  = rt_val_id;
    idex_d.imm     = imm_id;
    idex_d.rs      = rs_id;
    idex_d.rt      = rt_id;
    idex_d.dst     = dst_id;
    if (br_taken) begin
      pc_d   = br_target;
      ifid_d = '0;
      idex_d = '0;
    end else if (load_use) begin
      pc_d   = pc_q;
      ifid_d = ifid_q;
      idex_d = '0;
    end else if (jump_id) begin
      pc_d   = {6'd0, ifid_q.instr[25:0]};
      ifid_d = '0;
      idex_d = '0;
    end
  end

  always_comb begin
    exmem_d.reg_write  = idex_q.ctrl.reg_write;
    exmem_d.mem_to_reg = idex_q.ctrl.mem_to_reg;
    exmem_d.mem_write  = idex_q.ctrl.mem_write;
    exmem_d.res        = alu_res;
    exmem_d.store      = fwd_b;
    exmem_d.dst        = idex_q.dst;
    memwb_d.reg_write  = exmem_q.reg_write;
    memwb_d.mem_to_reg = exmem_q.mem_to_reg;
    memwb_d.res        = exmem_q.res;
    memwb_d.rdata      = ram_rd;
    memwb_d.dst        = exmem_q.dst;
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      pc_q    <= '0;
      ifid_q  <= '0;
      idex_q  <= '0;
      exmem_q <= '0;
      memwb_q <= '0;
    end else begin
      pc_q    <= pc_d;
      ifid_q  <= ifid_d;
      idex_q  <= idex_d;
      exmem_q <= exmem_d;
      memwb_q <= memwb_d;
    end
  end
endmodule

// File: tb/tb_mips_pipeline.sv
// Self-checking bench for mips_pipeline: directed programs from the test plan plus
// random programs compared against a sequential instruction-set model.

module tb_mips_pipeline;
  logic        clk = 1'b0;
  logic        clr = 1'b1;
  logic [31:0] alu;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] rom_img [256];
  logic [31:0] ram_img [256];
  logic [31:0] m_reg   [32];
  logic [31:0] m_ram   [256];
  logic [31:0] cap [$];

  localparam int NPROG = 24;

  mips_pipeline dut (.clk(clk), .clr(clr), .alu(alu));

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] enc_r(input logic [5:0] f, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [4:0] rd);
    return {6'h00, rs, rt, rd, 5'd0, f};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] enc_j(input logic [25:0] tgt);
    return {6'h02, tgt};
  endfunction

  task automatic clear_images();
    for (int i = 0; i < 256; i++) begin
      rom_img[i] = '0;
      ram_img[i] = '0;
    end
  endtask

  // Holds reset, loads both memories, then releases reset away from the clock edge.
  task automatic load_and_start();
    @(negedge clk);
    clr = 1'b1;
    for (int i = 0; i < 256; i++) begin
      dut.INSmemory.mem_array[i] = rom_img[i];
      dut.RAM.mem_array[i]       = ram_img[i];
    end
    @(negedge clk);
    @(negedge clk);
    clr = 1'b0;
  endtask

  task automatic run_capture(input int n);
    cap.delete();
    repeat (n) begin
      @(negedge clk);
      cap.push_back(alu);
    end
  endtask

  // Architectural model: one instruction at a time, no pipeline at all.
  task automatic iss_run(output logic done);
    logic [31:0] pc, ins, a, b, simm, zimm, npc;
    logic [4:0]  rs, rt, rd;
    done = 1'b0;
    for (int i = 0; i < 32; i++)  m_reg[i] = '0;
    for (int i = 0; i < 256; i++) m_ram[i] = ram_img[i];
    pc = '0;
    for (int step = 0; step < 5000 && !done; step++) begin
      ins  = rom_img[pc[7:0]];
      rs   = ins[25:21];
      rt   = ins[20:16];
      rd   = ins[15:11];
      a    = m_reg[rs];
      b    = m_reg[rt];
      simm = {{16{ins[15]}}, ins[15:0]};
      zimm = {16'd0, ins[15:0]};
      npc  = pc + 1;
      case (ins[31:26])
        6'h00: case (ins[5:0])
          6'h20: if (rd != 0) m_reg[rd] = a + b;
          6'h22: if (rd != 0) m_reg[rd] = a - b;
          6'h24: if (rd != 0) m_reg[rd] = a & b;
          6'h25: if (rd != 0) m_reg[rd] = a | b;
          6'h27: if (rd != 0) m_reg[rd] = ~(a | b);
          6'h2A: if (rd != 0) m_reg[rd] = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
          default: ;
        endcase
        6'h23: if (rt != 0) m_reg[rt] = m_ram[8'(a + simm)];
        6'h2B: m_ram[8'(a + simm)] = b;
        6'h08: if (rt != 0) m_reg[rt] = a + simm;
        6'h0D: if (rt != 0) m_reg[rt] = a | zimm;
        6'h04: if (a == b) npc = pc + 1 + simm;
        6'h02: npc = {6'd0, ins[25:0]};
        default: ;
      endcase
      if (ins[31:26] == 6'h02 && npc == pc) done = 1'b1;
      pc = npc;
    end
  endtask

  task automatic gen_random_program();
    logic [5:0] functs [6] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2A};
    logic [4:0] rs, rt, rd;
    clear_images();
    for (int i = 0; i < 256; i++) ram_img[i] = $urandom;
    for (int i = 0; i < NPROG; i++) begin
      rs = 5'($urandom_range(0, 7));
      rt = 5'($urandom_range(0, 7));
      rd = 5'($urandom_range(0, 7));
      case ($urandom_range(0, 9))
        0, 1, 2, 3: rom_img[i] = enc_r(functs[$urandom_range(0, 5)], rs, rt, rd);
        4: rom_img[i] = enc_i(6'h08, rs, rt, 16'($urandom));
        5: rom_img[i] = enc_i(6'h0D, rs, rt, 16'($urandom));
        6: rom_img[i] = enc_i(6'h23, rs, rt, 16'($urandom));
        7: rom_img[i] = enc_i(6'h2B, rs, rt, 16'($urandom));
        8: rom_img[i] = enc_i(6'h04, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                              16'($urandom_range(0, NPROG - 1 - i)));
        default:
          if ($urandom_range(0, 1) == 0) rom_img[i] = {6'h3F, 26'($urandom)};
          else rom_img[i] = enc_j(26'($urandom_range(i + 1, NPROG)));
      endcase
    end
    rom_img[NPROG] = enc_j(26'(NPROG));
  endtask

  task automatic load_program_a();
    logic [31:0] ra [11] = '{32'd8, 32'd6, 32'd5, 32'd1, 32'd7, 32'd9, 32'd8, 32'd4,
                             32'd5, 32'hA, 32'hFE0};
    logic [31:0] pa [16] = '{32'h8C000000, 32'h8C020008, 32'h8C040009, 32'h00441020,
                             32'h00401824, 32'h8C05000A, 32'h00A03825, 32'h8C060002,
                             32'h00E63825, 32'h0007502A, 32'h00E0582A, 32'h201FFFFF,
                             32'h1007270F, 32'h0800000F, 32'h10000000, 32'h0800000E};
    clear_images();
    for (int i = 0; i < 11; i++) ram_img[i] = ra[i];
    for (int i = 0; i < 16; i++) rom_img[i] = pa[i];
  endtask

  task automatic check_program_a(input string pfx);
    int idx [10]          = '{0, 2, 3, 4, 5, 6, 7, 10, 11, 31};
    logic [31:0] exp [10] = '{32'd0, 32'hF, 32'd0, 32'hA, 32'hFE0, 32'd5, 32'hFE5,
                              32'd1, 32'd0, 32'hFFFFFFFF};
    for (int i = 0; i < 10; i++)
      check($sformatf("%s R%0d", pfx, idx[i]), dut.Reg_Bank0.RB[idx[i]], exp[i]);
    for (int i = 0; i < 16; i++)
      check($sformatf("%s RAM[%0d]", pfx, i), dut.RAM.mem_array[i], ram_img[i]);
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      check($sformatf("%s pc loop c%0d", pfx, c),
            32'((dut.pc_q >= 32'd14) && (dut.pc_q <= 32'd16)), 32'd1);
    end
  endtask

  initial begin
    int   idx;
    logic done;

    // ---- Program A ----
    load_program_a();
    load_and_start();
    repeat (100) @(negedge clk);
    check_program_a("progA");

    // ---- Reset mid-run ----
    load_program_a();
    load_and_start();
    repeat (20) @(negedge clk);
    #2 clr = 1'b1;
    #1;
    check("rst pc", dut.pc_q, 32'd0);
    check("rst alu", alu, 32'd0);
    for (int i = 0; i < 32; i++)
      check($sformatf("rst R%0d", i), dut.Reg_Bank0.RB[i], 32'd0);
    @(negedge clk);
    check("rst hold R2", dut.Reg_Bank0.RB[2], 32'd0);
    check("rst hold alu", alu, 32'd0);
    clr = 1'b0;
    @(negedge clk);
    check("restart pc", dut.pc_q, 32'd1);
    check("restart instr", dut.ifid_q.instr, 32'h8C000000);
    repeat (100) @(negedge clk);
    check_program_a("restart");

    // ---- Load-use ----
    clear_images();
    ram_img[8] = 32'd5;
    rom_img[0] = enc_i(6'h23, 5'd0, 5'd2, 16'd8);
    rom_img[1] = enc_r(6'h20, 5'd2, 5'd2, 5'd3);
    rom_img[2] = enc_j(26'd2);
    load_and_start();
    run_capture(12);
    idx = -1;
    for (int i = 0; i < cap.size(); i++) if (idx < 0 && cap[i] == 32'd8) idx = i;
    check("lu lw seen", 32'(idx >= 0 && idx + 2 < cap.size()), 32'd1);
    if (idx >= 0 && idx + 2 < cap.size()) begin
      check("lu bubble", cap[idx + 1], 32'd0);
      check("lu add", cap[idx + 2], 32'hA);
    end
    check("lu R2", dut.Reg_Bank0.RB[2], 32'd5);
    check("lu R3", dut.Reg_Bank0.RB[3], 32'hA);

    // ---- Forwarding chain ----
    clear_images();
    rom_img[0] = enc_i(6'h08, 5'd0, 5'd1, 16'd3);
    rom_img[1] = enc_r(6'h20, 5'd1, 5'd1, 5'd2);
    rom_img[2] = enc_r(6'h22, 5'd2, 5'd1, 5'd5);
    rom_img[3] = enc_r(6'h27, 5'd5, 5'd0, 5'd6);
    rom_img[4] = enc_j(26'd4);
    load_and_start();
    run_capture(14);
    idx = -1;
    for (int i = 0; i < cap.size(); i++) if (idx < 0 && cap[i] == 32'd3) idx = i;
    check("fwd addi seen", 32'(idx >= 0 && idx + 3 < cap.size()), 32'd1);
    if (idx >= 0 && idx + 3 < cap.size()) begin
      check("fwd add alu", cap[idx + 1], 32'd6);
      check("fwd sub alu", cap[idx + 2], 32'd3);
      check("fwd nor alu", cap[idx + 3], 32'hFFFFFFFC);
    end
    check("fwd R2", dut.Reg_Bank0.RB[2], 32'd6);
    check("fwd R5", dut.Reg_Bank0.RB[5], 32'd3);
    check("fwd R6", dut.Reg_Bank0.RB[6], 32'hFFFFFFFC);

    // ---- Store / branch ----
    clear_images();
    rom_img[0] = enc_i(6'h08, 5'd0, 5'd1, 16'd7);
    rom_img[1] = enc_i(6'h2B, 5'd0, 5'd1, 16'd4);
    rom_img[2] = enc_i(6'h04, 5'd0, 5'd0, 16'd1);
    rom_img[3] = enc_i(6'h08, 5'd0, 5'd9, 16'd1);
    rom_img[4] = enc_i(6'h0D, 5'd0, 5'd8, 16'hA);
    rom_img[5] = enc_j(26'd5);
    load_and_start();
    repeat (20) @(negedge clk);
    check("sb RAM[4]", dut.RAM.mem_array[4], 32'd7);
    check("sb R1", dut.Reg_Bank0.RB[1], 32'd7);
    check("sb R9 skipped", dut.Reg_Bank0.RB[9], 32'd0);
    check("sb R8", dut.Reg_Bank0.RB[8], 32'hA);

    // ---- Random programs vs. instruction-set model ----
    for (int t = 0; t < 10; t++) begin
      gen_random_program();
      iss_run(done);
      check($sformatf("rand%0d model ends", t), 32'(done), 32'd1);
      load_and_start();
      repeat (4 * NPROG + 30) @(negedge clk);
      for (int i = 0; i < 32; i++)
        check($sformatf("rand%0d R%0d", t, i), dut.Reg_Bank0.RB[i], m_reg[i]);
      for (int i = 0; i < 256; i++)
        check($sformatf("rand%0d RAM[%0d]", t, i), dut.RAM.mem_array[i], m_ram[i]);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
